// File: rtl/chiplet_types_pkg.sv
// chiplet_types_pkg: shared flit and komma types for the chiplet link.
//   flit_meta_t    : per-packet routing metadata {vc, id, req}
//   flit_t         : metadata followed by a 56-bit payload
//   comma_header_t : payload layout of a komma (control) flit
//   ack_flit()     : builds the ACK komma flit that answers a packet header
package chiplet_types_pkg;

    typedef struct packed {
        logic       vc;
        logic [5:0] id;
        logic       req;
    } flit_meta_t;

    typedef struct packed {
        flit_meta_t  meta;
        logic [55:0] payload;
    } flit_t;

    typedef struct packed {
        logic [1:0]  format;
        logic [2:0]  comma_sel;
        logic [50:0] rsvd;
    } comma_header_t;

    localparam logic [1:0] KOMMA_PACKET = 2'd3;
    localparam logic [2:0] ACK_SEL      = 3'd1;

    function automatic flit_t ack_flit(input flit_meta_t m);
        comma_header_t c;
        c           = '0;
        c.format    = KOMMA_PACKET;
        c.comma_sel = ACK_SEL;
        ack_flit.meta    = m;
        ack_flit.payload = c;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: small synchronous FIFO used as the pending-ACK header queue.
//   CLK, nRST      : clock, async active-low reset
//   push / wdata   : enqueue (ignored when full)
//   pop            : dequeue head (ignored when empty)
//   rdata          : current head
//   empty / full   : registered occupancy flags
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = cnt_q == '0;
    assign full    = cnt_q == FULL_CNT;
    assign rdata   = mem[rp_q];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q == AW'(DEPTH-1) ? '0 : wp_q + 1'b1;
            if (do_pop) rp_q <= rp_q == AW'(DEPTH-1) ? '0 : rp_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wp_q] <= wdata;
    end

endmodule

// File: rtl/link_responder.sv
// link_responder: buffers received flits per packet, commits good packets to
// the consumer, drops bad ones, and answers each good packet with an ACK flit.
//   CLK, nRST                         : clock, async active-low reset
//   flit_rx/done_rx/packet_done_rx    : rx flit stream, last-flit marker
//   crc_corr_rx/err_rx                : packet CRC status, link error
//   out_flit/out_valid/out_ready      : committed flits to the consumer
//   flit_tx/start_tx/get_data         : ACK komma flit handshake to tx path
//   grtcred_tx                        : per-VC credit return, one per pop
//   drop_cnt                          : saturating count of dropped packets
module link_responder
    import chiplet_types_pkg::*;
#(
    parameter int FLIT_W = 64,
    parameter int DEPTH  = 8,
    parameter int HDRQ   = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [FLIT_W-1:0] flit_rx,
    input  logic              done_rx,
    input  logic              packet_done_rx,
    input  logic              crc_corr_rx,
    input  logic              err_rx,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FLIT_W-1:0] flit_tx,
    output logic              start_tx,
    input  logic              get_data,
    output logic [1:0]        grtcred_tx,
    output logic [15:0]       drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} tx_state_t;

    flit_t      mem [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
    logic       bad_q, bad_d, hdr_v_q, hdr_v_d;
    flit_meta_t hdr_q, hdr_d, first_meta, hq_head;
    logic [15:0] drop_q, drop_d;
    logic [1:0] cred_q, cred_d;
    tx_state_t  st_q;
    logic       start_q;
    flit_t      ftx_q, rx_f, rd_f;
    logic       full, wr_en, pkt_end, good, pop, hq_pop, hq_empty, hq_full;

    assign rx_f       = flit_t'(flit_rx[$bits(flit_t)-1:0]);
    assign rd_f       = mem[rd_ptr_q[AW-1:0]];
    // Occupancy includes uncommitted flits; a same-cycle pop does not free room.
    assign full       = (wr_ptr_q - rd_ptr_q) == FULL_OCC;
    assign wr_en      = done_rx & ~full;
    assign pkt_end    = done_rx & packet_done_rx;
    // A single-flit packet carries its header in the current flit.
    assign first_meta = hdr_v_q ? hdr_q : rx_f.meta;
    assign good       = pkt_end & crc_corr_rx & ~bad_q & ~full & ~err_rx & ~hq_full;
    assign out_valid  = rd_ptr_q != commit_ptr_q;
    assign pop        = out_valid & out_ready;
    assign hq_pop     = (st_q == WAIT) & get_data;
    assign out_flit   = FLIT_W'(rd_f);
    assign flit_tx    = FLIT_W'(ftx_q);
    assign start_tx   = start_q;
    assign grtcred_tx = cred_q;
    assign drop_cnt   = drop_q;

    always_comb begin
        wr_ptr_d     = pkt_end ? (good ? wr_ptr_q + 1'b1 : commit_ptr_q) : (wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q);
        commit_ptr_d = good ? wr_ptr_q + 1'b1 : commit_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        bad_d        = pkt_end ? 1'b0 : bad_q | (done_rx & full) | (err_rx & (hdr_v_q | done_rx));
        hdr_v_d      = pkt_end ? 1'b0 : hdr_v_q | done_rx;
        hdr_d        = first_meta;
        drop_d       = (pkt_end & ~good & ~&drop_q) ? drop_q + 1'b1 : drop_q;
        cred_d       = pop ? 2'b01 << rd_f.meta.vc : 2'b00;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            bad_q        <= 1'b0;
            hdr_v_q      <= 1'b0;
            hdr_q        <= '0;
            drop_q       <= '0;
            cred_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            bad_q        <= bad_d;
            hdr_v_q      <= hdr_v_d;
            hdr_q        <= hdr_d;
            drop_q       <= drop_d;
            cred_q       <= cred_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= rx_f;
    end

    sync_fifo #(.W($bits(flit_meta_t)), .DEPTH(HDRQ)) u_hdrq (
        .CLK  (CLK),
        .nRST (nRST),
        .push (good),
        .wdata(first_meta),
        .pop  (hq_pop),
        .rdata(hq_head),
        .empty(hq_empty),
        .full (hq_full)
    );

    // flit_tx is captured on entry to REQ and held through WAIT.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            st_q    <= IDLE;
            start_q <= 1'b0;
            ftx_q   <= '0;
        end else begin
            start_q <= 1'b0;
            case (st_q)
                IDLE: if (!hq_empty) begin
                    st_q    <= REQ;
                    start_q <= 1'b1;
                    ftx_q   <= ack_flit(hq_head);
                end
                REQ:  st_q <= WAIT;
                WAIT: if (get_data) st_q <= IDLE;
                default: st_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_link_responder.sv
// tb_link_responder: directed bench with a queue-level reference model.
module tb_link_responder;
    import chiplet_types_pkg::*;

    localparam int DEPTH = 8;
    localparam int HDRQ  = 4;

    logic        CLK = 1'b0, nRST = 1'b0;
    logic [63:0] flit_rx = '0;
    logic        done_rx = 1'b0, packet_done_rx = 1'b0, crc_corr_rx = 1'b0, err_rx = 1'b0;
    logic [63:0] out_flit, flit_tx;
    logic        out_valid, out_ready = 1'b1, start_tx, get_data = 1'b1;
    logic [1:0]  grtcred_tx;
    logic [15:0] drop_cnt;

    always #5 CLK = ~CLK;

    link_responder #(.FLIT_W(64), .DEPTH(DEPTH), .HDRQ(HDRQ)) dut (
        .CLK(CLK), .nRST(nRST), .flit_rx(flit_rx), .done_rx(done_rx),
        .packet_done_rx(packet_done_rx), .crc_corr_rx(crc_corr_rx), .err_rx(err_rx),
        .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
        .flit_tx(flit_tx), .start_tx(start_tx), .get_data(get_data),
        .grtcred_tx(grtcred_tx), .drop_cnt(drop_cnt)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic flit_t mk(input logic vc, input logic [5:0] id, input int i);
        flit_t f;
        f.meta.vc  = vc;
        f.meta.id  = id;
        f.meta.req = 1'b1;
        f.payload  = (56'(id) << 8) | 56'(i);
        return f;
    endfunction

    function automatic logic [63:0] exp_ack(input flit_meta_t m);
        flit_t a;
        comma_header_t c;
        c = '0;
        c.format    = KOMMA_PACKET;
        c.comma_sel = ACK_SEL;
        a.meta      = m;
        a.payload   = c;
        return a;
    endfunction

    // Reference model: packets as queues of flits, ACKs as a queue of headers.
    flit_t      committed[$], pend[$];
    flit_meta_t hq[$];
    flit_meta_t hdr;
    bit         have_hdr = 0, bad = 0;
    int         tx_age = 0;
    logic [15:0] m_drop = '0;
    logic [1:0]  m_cred = '0;

    task automatic model_step();
        bit    full, hqf;
        flit_t f;
        if (!nRST) begin
            committed.delete(); pend.delete(); hq.delete();
            have_hdr = 0; bad = 0; tx_age = 0; m_drop = '0; m_cred = '0;
            return;
        end
        full = (committed.size() + pend.size()) >= DEPTH;
        hqf  = hq.size() >= HDRQ;
        if (hq.size() == 0) tx_age = 0;
        else if (tx_age >= 2 && get_data) begin
            void'(hq.pop_front());
            tx_age = 0;
        end else tx_age++;
        m_cred = '0;
        if (committed.size() > 0 && out_ready) begin
            f = committed.pop_front();
            m_cred[f.meta.vc] = 1'b1;
        end
        if (done_rx) begin
            f = flit_t'(flit_rx);
            if (!have_hdr) begin
                hdr = f.meta;
                have_hdr = 1;
            end
            if (full || err_rx) bad = 1;
            if (!full) pend.push_back(f);
            if (packet_done_rx) begin
                if (crc_corr_rx && !bad && !hqf) begin
                    foreach (pend[i]) committed.push_back(pend[i]);
                    hq.push_back(hdr);
                end else if (m_drop != 16'hffff) m_drop++;
                pend.delete();
                bad = 0;
                have_hdr = 0;
            end
        end else if (err_rx && have_hdr) bad = 1;
    endtask

    initial forever begin
        @(posedge CLK or negedge nRST);
        model_step();
    end

    int          ack_ids[$];
    logic [63:0] ack_flits[$];
    logic [55:0] out_pl[$];
    int          n_out = 0, n_cred0 = 0, n_cred1 = 0;

    always @(negedge CLK) begin : cmp
        flit_t t;
        chk("out_valid", out_valid, committed.size() > 0);
        if (committed.size() > 0) chk("out_flit", out_flit, committed[0]);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("grtcred_tx", grtcred_tx, m_cred);
        chk("start_tx", start_tx, hq.size() > 0 && tx_age == 1);
        if (hq.size() > 0 && tx_age >= 1) chk("flit_tx", flit_tx, exp_ack(hq[0]));
        t = flit_tx;
        if (start_tx) begin
            ack_ids.push_back(int'(t.meta.id));
            ack_flits.push_back(flit_tx);
        end
        if (grtcred_tx[0]) n_cred0++;
        if (grtcred_tx[1]) n_cred1++;
        if (out_valid && out_ready) begin
            n_out++;
            out_pl.push_back(out_flit[55:0]);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic idle(input int k);
        repeat (k) tick();
    endtask

    task automatic clear_obs();
        ack_ids.delete(); ack_flits.delete(); out_pl.delete();
        n_out = 0; n_cred0 = 0; n_cred1 = 0;
    endtask

    task automatic send(input int n, input logic vc, input logic [5:0] id,
                        input logic crc, input int err_at, input bit close);
        for (int i = 0; i < n; i++) begin
            done_rx        = 1'b1;
            packet_done_rx = close && (i == n - 1);
            crc_corr_rx    = crc;
            err_rx         = (i == err_at);
            flit_rx        = mk(vc, id, i);
            tick();
        end
        done_rx = 1'b0; packet_done_rx = 1'b0; err_rx = 1'b0; crc_corr_rx = 1'b0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_start_tx", start_tx, 0);
        chk("rst_grtcred", grtcred_tx, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        idle(2);
        nRST = 1'b1;
        tick();
        clear_obs();
    endtask

    initial begin
        idle(2);
        do_reset();

        // good 3-flit packet on vc0
        send(3, 1'b0, 6'd5, 1'b1, -1, 1);
        idle(12);
        chk("t1_outs", n_out, 3);
        chk("t1_cred0", n_cred0, 3);
        chk("t1_nacks", ack_ids.size(), 1);
        if (ack_ids.size() > 0) chk("t1_ack_flit", ack_flits[0], 64'h0BC8_0000_0000_0000);
        if (out_pl.size() == 3) begin
            chk("t1_pl0", out_pl[0], 56'h500);
            chk("t1_pl2", out_pl[2], 56'h502);
        end

        // bad CRC, then a good packet must start at the rewound pointer
        do_reset();
        send(3, 1'b0, 6'd7, 1'b0, -1, 1);
        idle(10);
        chk("t2_outs", n_out, 0);
        chk("t2_drop", drop_cnt, 1);
        chk("t2_nacks", ack_ids.size(), 0);
        send(1, 1'b0, 6'd8, 1'b1, -1, 1);
        idle(8);
        chk("t2_after_outs", n_out, 1);
        if (out_pl.size() > 0) chk("t2_after_pl", out_pl[0], 56'h800);

        // overflow of the flit buffer
        do_reset();
        out_ready = 1'b0;
        send(10, 1'b1, 6'd9, 1'b1, -1, 1);
        idle(3);
        chk("t3_drop", drop_cnt, 1);
        chk("t3_valid", out_valid, 0);
        send(2, 1'b1, 6'd10, 1'b1, -1, 1);
        idle(2);
        out_ready = 1'b1;
        idle(10);
        chk("t3_outs", n_out, 2);
        chk("t3_cred1", n_cred1, 2);
        if (out_pl.size() == 2) begin
            chk("t3_pl0", out_pl[0], 56'hA00);
            chk("t3_pl1", out_pl[1], 56'hA01);
        end
        chk("t3_nacks", ack_ids.size(), 1);

        // header queue overflow
        do_reset();
        get_data = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send(1, 1'b0, 6'(12 + k), 1'b1, -1, 1);
            idle(1);
        end
        idle(5);
        chk("t4_drop", drop_cnt, 1);
        chk("t4_nacks_held", ack_ids.size(), 1);
        get_data = 1'b1;
        idle(30);
        chk("t4_nacks", ack_ids.size(), 4);
        if (ack_ids.size() == 4) begin
            chk("t4_ack0", ack_ids[0], 12);
            chk("t4_ack1", ack_ids[1], 13);
            chk("t4_ack2", ack_ids[2], 14);
            chk("t4_ack3", ack_ids[3], 15);
        end
        chk("t4_outs", n_out, 4);

        // err_rx on flit 2 of 4
        do_reset();
        send(4, 1'b0, 6'd20, 1'b1, 1, 1);
        idle(8);
        chk("t5_drop", drop_cnt, 1);
        chk("t5_outs", n_out, 0);
        chk("t5_nacks", ack_ids.size(), 0);

        // reset mid-packet and in WAIT (drop_cnt is 1 here)
        get_data = 1'b0;
        out_ready = 1'b0;
        send(1, 1'b1, 6'd30, 1'b1, -1, 1);
        idle(4);
        chk("t6_pre_nacks", ack_ids.size(), 1);
        chk("t6_pre_valid", out_valid, 1);
        send(2, 1'b0, 6'd31, 1'b1, -1, 0);
        do_reset();
        get_data = 1'b1;
        out_ready = 1'b1;
        send(2, 1'b0, 6'd32, 1'b1, -1, 1);
        idle(12);
        chk("t6_outs", n_out, 2);
        chk("t6_nacks", ack_ids.size(), 1);
        if (ack_ids.size() > 0) chk("t6_ack_id", ack_ids[0], 32);
        chk("t6_drop", drop_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
